// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch slice: FSM state encoding, the NOP
// word loaded into the instruction register at reset, and the default
// datapath width.
package riscv_pkg;

    localparam int WIDTH_DEFAULT = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ   = 2'b00,
        S_VALID = 2'b01,
        S_HALT  = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ack bus between the fetch unit (master)
// and the instruction memory (slave).
interface fetch_unit_if
    import riscv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);

    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic [31:0]      imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/pc_next.sv
// Next-PC arithmetic: sequential PC+4, branch target PC+imm (both wrap
// modulo 2^WIDTH), and the selected next PC. The selected branch target
// always has bits [1:0] cleared; when misaligned targets are trapped
// upstream the PC is never loaded from a misaligned target, so the mask
// is harmless there.
module pc_next
    import riscv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] imm,
    input  logic             pcsrc,
    output logic [WIDTH-1:0] pcplus4,
    output logic [WIDTH-1:0] pctarget,
    output logic [WIDTH-1:0] pcnext
);

    assign pcplus4  = pc + WIDTH'(4);
    assign pctarget = pc + imm;
    assign pcnext   = pcsrc ? {pctarget[WIDTH-1:2], 2'b00} : pcplus4;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: a three-state REQ/VALID/HALT FSM that requests
// the word at PC, latches it into Instr on ack, holds it until the
// downstream stage advances, then steps PC sequentially or to a target.
//
// Build option: define FETCH_MISALIGN_CHECK_EN to trap branch targets
// with nonzero bits [1:0] (sticky misalign_err, PC held, unit halts
// until reset). Without it such targets are taken with [1:0] cleared.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int               WIDTH    = WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             advance,
    input  logic             PCSrc,
    input  logic [WIDTH-1:0] ImmExt,
    fetch_unit_if.master     imem,
    output logic [31:0]      Instr,
    output logic             instr_valid,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PCPlus4,
    output logic [WIDTH-1:0] PCTarget,
    output logic             misalign_err
);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_sel;
    logic [31:0]      instr_q;
    logic             valid_q;
    logic             ld_instr;
    logic             ld_pc;
    logic             target_bad;

    pc_next #(.WIDTH(WIDTH)) u_pc_next (
        .pc       (pc_q),
        .imm      (ImmExt),
        .pcsrc    (PCSrc),
        .pcplus4  (PCPlus4),
        .pctarget (PCTarget),
        .pcnext   (pc_sel)
    );

`ifdef FETCH_MISALIGN_CHECK_EN
    assign target_bad = PCSrc & (PCTarget[1:0] != 2'b00);
`else
    assign target_bad = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_REQ;
        else          state_q <= state_d;
    end

    // Next-state and register-load decode; advance only matters in VALID,
    // ack only in REQ
    always_comb begin
        state_d  = state_q;
        ld_instr = 1'b0;
        ld_pc    = 1'b0;
        case (state_q)
            S_REQ: begin
                if (imem.imem_ack) begin
                    ld_instr = 1'b1;
                    state_d  = S_VALID;
                end
            end
            S_VALID: begin
                if (advance) begin
                    if (target_bad) begin
                        state_d = S_HALT;
                    end else begin
                        ld_pc   = 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_REQ;
        endcase
    end

    // PC, instruction register and valid flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else begin
            if (ld_instr) begin
                instr_q <= imem.imem_rdata;
                valid_q <= 1'b1;
            end
            if (ld_pc) begin
                pc_q    <= pc_sel;
                valid_q <= 1'b0;
            end
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // Sticky misaligned-target flag, cleared only by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            misalign_err <= 1'b0;
        else if (state_q == S_VALID && advance && target_bad)
            misalign_err <= 1'b1;
    end
`else
    assign misalign_err = 1'b0;
`endif

    // Gate the request with reset so it drops the instant reset asserts,
    // even though the state register already reads REQ during reset.
    assign imem.imem_req  = reset_n & (state_q == S_REQ);
    assign imem.imem_addr = pc_q;

    assign PC          = pc_q;
    assign Instr       = instr_q;
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed and randomized fetch /
// advance sequences against a transaction-level model of PC and Instr.
module tb_fetch_unit;

    localparam int          W        = 32;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          advance = 1'b0;
    logic          PCSrc = 1'b0;
    logic [W-1:0]  ImmExt = '0;
    logic [31:0]   Instr;
    logic          instr_valid;
    logic [W-1:0]  PC, PCPlus4, PCTarget;
    logic          misalign_err;

    fetch_unit_if #(.WIDTH(W)) imem ();

    fetch_unit #(.WIDTH(W), .RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .advance      (advance),
        .PCSrc        (PCSrc),
        .ImmExt       (ImmExt),
        .imem         (imem),
        .Instr        (Instr),
        .instr_valid  (instr_valid),
        .PC           (PC),
        .PCPlus4      (PCPlus4),
        .PCTarget     (PCTarget),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: architectural view per transaction
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_instr = NOP_WORD;
    logic        m_valid = 1'b0;
    logic        m_mis   = 1'b0;
    logic        m_halt  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // In REQ: withhold ack for wait_cyc cycles (random advance/PCSrc noise
    // that must be ignored), then ack with data.
    task automatic fetch(input int wait_cyc, input logic [31:0] data);
        for (int i = 0; i < wait_cyc; i++) begin
            imem.imem_ack   = 1'b0;
            imem.imem_rdata = $urandom;
            advance         = 1'($urandom_range(0, 1));
            PCSrc           = 1'($urandom_range(0, 1));
            ImmExt          = $urandom;
            #1;
            chk("wait_req", {31'b0, imem.imem_req}, 32'h1);
            chk("wait_addr", imem.imem_addr, m_pc);
            @(negedge clk);
            chk("wait_instr", Instr, m_instr);
            chk("wait_valid", {31'b0, instr_valid}, 32'h0);
            chk("wait_pc", PC, m_pc);
        end
        advance         = 1'($urandom_range(0, 1));
        imem.imem_ack   = 1'b1;
        imem.imem_rdata = data;
        #1;
        chk("ack_req", {31'b0, imem.imem_req}, 32'h1);
        chk("ack_addr", imem.imem_addr, m_pc);
        @(negedge clk);
        imem.imem_ack = 1'b0;
        advance       = 1'b0;
        m_instr       = data;
        m_valid       = 1'b1;
        chk("fetch_instr", Instr, m_instr);
        chk("fetch_valid", {31'b0, instr_valid}, 32'h1);
        chk("fetch_pc", PC, m_pc);
        chk("fetch_req", {31'b0, imem.imem_req}, 32'h0);
    endtask

    // In VALID: hold for some cycles (random ack noise), then advance.
    task automatic step(input logic src, input logic [31:0] imm, input int hold);
        logic [32:0] tgt;
        for (int i = 0; i < hold; i++) begin
            advance         = 1'b0;
            imem.imem_ack   = 1'($urandom_range(0, 1));
            imem.imem_rdata = $urandom;
            @(negedge clk);
            chk("hold_instr", Instr, m_instr);
            chk("hold_valid", {31'b0, instr_valid}, 32'h1);
            chk("hold_req", {31'b0, imem.imem_req}, 32'h0);
            chk("hold_pc", PC, m_pc);
        end
        imem.imem_ack = 1'($urandom_range(0, 1));
        advance       = 1'b1;
        PCSrc         = src;
        ImmExt        = imm;
        #1;
        chk("pcplus4", PCPlus4, (m_pc + 32'd4) % 33'h1_0000_0000);
        tgt = ({1'b0, m_pc} + {1'b0, imm}) % 33'h1_0000_0000;
        chk("pctarget", PCTarget, tgt[31:0]);
`ifdef FETCH_MISALIGN_CHECK_EN
        if (src && (tgt % 4 != 0)) begin
            m_mis  = 1'b1;
            m_halt = 1'b1;
        end else
`endif
        begin
            m_pc    = src ? (tgt[31:0] - (tgt[31:0] % 4)) : ((m_pc + 32'd4) % 33'h1_0000_0000);
            m_valid = 1'b0;
        end
        @(negedge clk);
        advance       = 1'b0;
        imem.imem_ack = 1'b0;
        chk("step_pc", PC, m_pc);
        chk("step_addr", imem.imem_addr, m_pc);
        chk("step_valid", {31'b0, instr_valid}, {31'b0, m_valid});
        chk("step_instr", Instr, m_instr);
        chk("step_mis", {31'b0, misalign_err}, {31'b0, m_mis});
        chk("step_req", {31'b0, imem.imem_req}, {31'b0, !m_halt});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] imm;
        logic        src;

        // reset with ack tied high: ack during reset must not load Instr
        imem.imem_ack   = 1'b1;
        imem.imem_rdata = 32'h0124_E68F;
        advance         = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req", {31'b0, imem.imem_req}, 32'h0);
        chk("rst_pc", PC, 32'h0);
        chk("rst_instr", Instr, NOP_WORD);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_mis", {31'b0, misalign_err}, 32'h0);

        // first request immediately after release, word visible next cycle
        reset_n = 1'b1;
        advance = 1'b0;
        #1;
        chk("rel_req", {31'b0, imem.imem_req}, 32'h1);
        chk("rel_addr", imem.imem_addr, 32'h0);
        @(negedge clk);
        imem.imem_ack = 1'b0;
        m_instr = 32'h0124_E68F;
        m_valid = 1'b1;
        chk("first_instr", Instr, 32'h0124_E68F);
        chk("first_valid", {31'b0, instr_valid}, 32'h1);
        chk("first_pc", PC, 32'h0);

        // directed: reach 0x100, sequential and backward branch from there
        step(1'b1, 32'h0000_0100, 1);
        fetch(0, 32'hDEAD_0001);
        step(1'b0, 32'h0, 0);
        chk("seq_0x104", imem.imem_addr, 32'h0000_0104);
        fetch(1, 32'hDEAD_0002);
        step(1'b1, 32'hFFFF_FFFC, 0);
        fetch(0, 32'hDEAD_0003);
        step(1'b1, 32'hFFFF_FFF0, 0);
        chk("br_0x0f0", imem.imem_addr, 32'h0000_00F0);

        // ack withheld 5 cycles
        fetch(5, 32'hDEAD_0004);

        // wraparound: 0xF0 -> 0xFFFF_FFFC -> 0
        step(1'b1, 32'hFFFF_FF0C, 2);
        chk("br_top", imem.imem_addr, 32'hFFFF_FFFC);
        fetch(0, 32'hDEAD_0005);
        step(1'b0, 32'h0, 0);
        chk("wrap_zero", imem.imem_addr, 32'h0);
        fetch(2, 32'hDEAD_0006);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            src = 1'($urandom_range(0, 1));
            imm = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
            imm[1:0] = 2'b00;
`endif
            step(src, imm, $urandom_range(0, 2));
            fetch($urandom_range(0, 3), $urandom);
        end

        // reset pulse mid-request
        step(1'b0, 32'h0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_req", {31'b0, imem.imem_req}, 32'h0);
        imem.imem_ack   = 1'b1;
        imem.imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        m_pc = 32'h0; m_instr = NOP_WORD; m_valid = 1'b0; m_mis = 1'b0; m_halt = 1'b0;
        chk("midrst_pc", PC, 32'h0);
        chk("midrst_instr", Instr, NOP_WORD);
        chk("midrst_valid", {31'b0, instr_valid}, 32'h0);
        imem.imem_ack = 1'b0;
        reset_n = 1'b1;
        #1;
        chk("midrst_rel_req", {31'b0, imem.imem_req}, 32'h1);
        chk("midrst_rel_addr", imem.imem_addr, 32'h0);
        fetch(1, 32'hDEAD_0007);

        // misaligned branch target from 0x100
        step(1'b1, 32'h0000_0100, 0);
        fetch(0, 32'hDEAD_0008);
        step(1'b1, 32'h0000_0002, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("mis_flag", {31'b0, misalign_err}, 32'h1);
        chk("mis_pc", PC, 32'h0000_0100);
        chk("mis_req", {31'b0, imem.imem_req}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            advance         = 1'($urandom_range(0, 1));
            PCSrc           = 1'($urandom_range(0, 1));
            imem.imem_ack   = 1'($urandom_range(0, 1));
            imem.imem_rdata = $urandom;
            @(negedge clk);
            chk("halt_req", {31'b0, imem.imem_req}, 32'h0);
            chk("halt_pc", PC, 32'h0000_0100);
            chk("halt_instr", Instr, 32'hDEAD_0008);
            chk("halt_mis", {31'b0, misalign_err}, 32'h1);
        end
`else
        chk("mis_masked_addr", imem.imem_addr, 32'h0000_0100);
        chk("mis_tied", {31'b0, misalign_err}, 32'h0);
        fetch(0, 32'hDEAD_0009);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
